// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a two-flop input synchroniser, feeding a
// small show-ahead FIFO. Framing and overrun faults are latched in sticky flags
// until err_clr is pulsed.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned HALF_BIT     = 5208,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_txd_in,
    input  logic       rx_rd,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    // Counter wide enough for the full bit period.
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    // FIFO address width; pointers carry one extra wrap bit.
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    // Synchroniser
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;

    // Receiver FSM
    state_t          r_state;
    state_t          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_next;
    logic [7:0]      r_shreg;
    logic [7:0]      w_shreg_next;
    logic            w_push;
    logic            w_frame_bad;

    // FIFO
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_ovf;

    // Sticky flags
    logic            r_frame_err;
    logic            r_overrun;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_txd_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Receiver FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shreg <= w_shreg_next;
        end
    end

    // Next-state logic: mid-bit sampling, LSB-first shift, stop-bit check.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shreg_next = r_shreg;
        w_push       = 1'b0;
        w_frame_bad  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_next = StStart;
                    w_cnt_next   = '0;
                end
            end

            StStart: begin
                if (r_cnt == HalfLast) begin
                    w_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next = StData;
                        w_idx_next   = '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as noise.
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            StData: begin
                if (r_cnt == BitLast) begin
                    w_cnt_next   = '0;
                    w_shreg_next = {w_rx_s, r_shreg[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_next = StStop;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            StStop: begin
                if (r_cnt == BitLast) begin
                    // Return to idle mid stop bit so a following start edge is caught.
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                    if (w_rx_s) begin
                        w_push = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FIFO status and write/read qualification.
    always_comb begin
        w_empty = (r_wp == r_rp);
        w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
        w_pop   = rx_rd && !w_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        w_wr    = w_push && (!w_full || w_pop);
        w_ovf   = w_push && w_full && !w_pop;
    end

    // FIFO storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= r_shreg;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Outputs: show-ahead head byte, forced to zero while empty.
    always_comb begin
        rx_data   = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
        rx_empty  = w_empty;
        busy      = (r_state != StIdle);
        frame_err = r_frame_err;
        overrun   = r_overrun;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios for the UART receiver and its FIFO,
// using a short bit period so frames take 160 clocks.
module tb_uart_rx_fifo;

    localparam int unsigned Clks  = 16;
    localparam int unsigned Half  = 8;
    localparam int unsigned Depth = 4;
    // Negedges from the start-bit drive until the stop-bit sample edge.
    localparam int unsigned PushEdge = 154;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       uart_txd_in = 1'b1;
    logic       rx_rd       = 1'b0;
    logic       err_clr     = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks    = 0;
    int failures  = 0;
    int fall_cnt  = 0;
    int busy_rise = 0;
    logic prev_empty = 1'b1;
    logic prev_busy  = 1'b0;

    logic [7:0] hello [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    uart_rx_fifo #(
        .CLKS_PER_BIT (Clks),
        .HALF_BIT     (Half),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_txd_in (uart_txd_in),
        .rx_rd       (rx_rd),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Count rx_empty falling edges and busy rising edges.
    always @(negedge clk) begin
        prev_empty <= rx_empty;
        prev_busy  <= busy;
        if (prev_empty && !rx_empty) fall_cnt <= fall_cnt + 1;
        if (!prev_busy && busy) busy_rise <= busy_rise + 1;
    end

    // Drive one 8N1 frame, starting at the current negedge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        uart_txd_in = 1'b0;
        repeat (Clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_txd_in = data[i];
            repeat (Clks) @(negedge clk);
        end
        uart_txd_in = stop_bit;
        repeat (Clks) @(negedge clk);
        uart_txd_in = 1'b1;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data got=%h exp=00", rx_data); failures++; end checks++;
        if (rx_empty !== 1'b1) begin $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); failures++; end checks++;
        if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err got=%b exp=0", frame_err); failures++; end checks++;
        if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%b exp=0", overrun); failures++; end checks++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        if (busy !== 1'b0) begin $display("FAIL idle_busy got=%b exp=0", busy); failures++; end checks++;
    endtask

    task automatic test_single_frame();
        int base;
        pop();  // pop while empty must be ignored
        @(negedge clk);
        if (rx_empty !== 1'b1) begin $display("FAIL pop_empty got=%b exp=1", rx_empty); failures++; end checks++;
        base = fall_cnt;
        send_frame(8'h48, 1'b1);
        repeat (4) @(negedge clk);
        if (fall_cnt - base !== 1) begin $display("FAIL single_falls got=%0d exp=1", fall_cnt - base); failures++; end checks++;
        if (rx_data !== 8'h48) begin $display("FAIL single_data got=%h exp=48", rx_data); failures++; end checks++;
        if (frame_err !== 1'b0) begin $display("FAIL single_frame_err got=%b exp=0", frame_err); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL single_busy got=%b exp=0", busy); failures++; end checks++;
        pop();
        if (rx_empty !== 1'b1) begin $display("FAIL single_pop_empty got=%b exp=1", rx_empty); failures++; end checks++;
        if (rx_data !== 8'h00) begin $display("FAIL single_pop_data got=%h exp=00", rx_data); failures++; end checks++;
    endtask

    task automatic test_glitch();
        int base;
        base = busy_rise;
        uart_txd_in = 1'b0;
        repeat (4) @(negedge clk);
        uart_txd_in = 1'b1;
        repeat (20) @(negedge clk);
        if (busy_rise - base !== 1) begin $display("FAIL glitch_busy_pulse got=%0d exp=1", busy_rise - base); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL glitch_busy got=%b exp=0", busy); failures++; end checks++;
        if (rx_empty !== 1'b1) begin $display("FAIL glitch_empty got=%b exp=1", rx_empty); failures++; end checks++;
        if (frame_err !== 1'b0) begin $display("FAIL glitch_frame_err got=%b exp=0", frame_err); failures++; end checks++;
        if (overrun !== 1'b0) begin $display("FAIL glitch_overrun got=%b exp=0", overrun); failures++; end checks++;
    endtask

    task automatic test_frame_err();
        // err_clr lands on the same edge as the bad stop-bit sample: the error must win.
        fork
            send_frame(8'h55, 1'b0);
            begin
                repeat (PushEdge) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        if (frame_err !== 1'b1) begin $display("FAIL ferr_set got=%b exp=1", frame_err); failures++; end checks++;
        if (rx_empty !== 1'b1) begin $display("FAIL ferr_empty got=%b exp=1", rx_empty); failures++; end checks++;
        if (overrun !== 1'b0) begin $display("FAIL ferr_overrun got=%b exp=0", overrun); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL ferr_busy got=%b exp=0", busy); failures++; end checks++;
        clear_err();
        if (frame_err !== 1'b0) begin $display("FAIL ferr_clear got=%b exp=0", frame_err); failures++; end checks++;
    endtask

    task automatic test_overrun();
        for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1);
        repeat (4) @(negedge clk);
        if (overrun !== 1'b0) begin $display("FAIL ovr_full_no_flag got=%b exp=0", overrun); failures++; end checks++;
        if (rx_data !== 8'h01) begin $display("FAIL ovr_head got=%h exp=01", rx_data); failures++; end checks++;
        send_frame(8'h05, 1'b1);
        repeat (4) @(negedge clk);
        if (overrun !== 1'b1) begin $display("FAIL ovr_set got=%b exp=1", overrun); failures++; end checks++;
        for (int i = 1; i <= 4; i++) begin
            if (rx_data !== 8'(i)) begin $display("FAIL ovr_pop%0d got=%h exp=%h", i, rx_data, 8'(i)); failures++; end checks++;
            pop();
        end
        if (rx_empty !== 1'b1) begin $display("FAIL ovr_drained got=%b exp=1", rx_empty); failures++; end checks++;
        clear_err();
        if (overrun !== 1'b0) begin $display("FAIL ovr_clear got=%b exp=0", overrun); failures++; end checks++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_q [4] = '{8'h12, 8'h13, 8'h14, 8'h15};
        for (int d = 0; d < 4; d++) send_frame(8'h11 + 8'(d), 1'b1);
        // Full FIFO: push and pop on the same edge.
        fork
            send_frame(8'h15, 1'b1);
            begin
                repeat (PushEdge) @(negedge clk);
                pop();
            end
        join
        repeat (4) @(negedge clk);
        if (overrun !== 1'b0) begin $display("FAIL full_pushpop_overrun got=%b exp=0", overrun); failures++; end checks++;
        for (int i = 0; i < 4; i++) begin
            if (rx_data !== exp_q[i]) begin $display("FAIL full_pushpop_pop%0d got=%h exp=%h", i, rx_data, exp_q[i]); failures++; end checks++;
            pop();
        end
        if (rx_empty !== 1'b1) begin $display("FAIL full_pushpop_drained got=%b exp=1", rx_empty); failures++; end checks++;
        // One entry: push and pop on the same edge.
        send_frame(8'h21, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (PushEdge) @(negedge clk);
                pop();
                if (rx_empty !== 1'b0) begin $display("FAIL one_pushpop_empty got=%b exp=0", rx_empty); failures++; end checks++;
                if (rx_data !== 8'h22) begin $display("FAIL one_pushpop_data got=%h exp=22", rx_data); failures++; end checks++;
            end
        join
        pop();
        if (rx_empty !== 1'b1) begin $display("FAIL one_pushpop_drained got=%b exp=1", rx_empty); failures++; end checks++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] part;
        int base;
        part = 8'hC3;
        send_frame(8'h33, 1'b1);
        uart_txd_in = 1'b0;
        repeat (Clks) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_txd_in = part[i];
            repeat (Clks) @(negedge clk);
        end
        uart_txd_in = part[3];
        repeat (Clks / 2) @(negedge clk);
        if (busy !== 1'b1) begin $display("FAIL midrst_busy_before got=%b exp=1", busy); failures++; end checks++;
        reset = 1'b1;
        uart_txd_in = 1'b1;
        repeat (2) @(negedge clk);
        if (rx_empty !== 1'b1) begin $display("FAIL midrst_flushed got=%b exp=1", rx_empty); failures++; end checks++;
        if (busy !== 1'b0) begin $display("FAIL midrst_busy got=%b exp=0", busy); failures++; end checks++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        base = fall_cnt;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        if (fall_cnt - base !== 1) begin $display("FAIL midrst_falls got=%0d exp=1", fall_cnt - base); failures++; end checks++;
        if (rx_data !== 8'hA5) begin $display("FAIL midrst_data got=%h exp=a5", rx_data); failures++; end checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL midrst_flags got=%b%b exp=00", frame_err, overrun); failures++;
        end
        checks++;
        pop();
        if (rx_empty !== 1'b1) begin $display("FAIL midrst_drained got=%b exp=1", rx_empty); failures++; end checks++;
    endtask

    task automatic test_back_to_back();
        int k;
        int budget;
        k = 0;
        budget = 0;
        fork
            for (int i = 0; i < 14; i++) send_frame(hello[i], 1'b1);
            begin
                while (k < 14 && budget < 14 * 160 + 400) begin
                    @(negedge clk);
                    budget++;
                    if (rx_rd) begin
                        rx_rd = 1'b0;
                    end else if (!rx_empty) begin
                        if (rx_data !== hello[k]) begin
                            $display("FAIL b2b_byte%0d got=%h exp=%h", k, rx_data, hello[k]); failures++;
                        end
                        checks++;
                        k++;
                        rx_rd = 1'b1;
                    end
                end
                @(negedge clk);
                rx_rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        if (k !== 14) begin $display("FAIL b2b_count got=%0d exp=14", k); failures++; end checks++;
        if (frame_err !== 1'b0) begin $display("FAIL b2b_frame_err got=%b exp=0", frame_err); failures++; end checks++;
        if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got=%b exp=0", overrun); failures++; end checks++;
        if (rx_empty !== 1'b1) begin $display("FAIL b2b_drained got=%b exp=1", rx_empty); failures++; end checks++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_same_cycle();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
